simon_host_ctrl: RTL and testbench

Synthesizable initiator for the SIMON 48/72 core handshake (newKey/ldKey/doneKey, newData/ldData/doneData/readData). It takes keys and plaintext blocks from an upstream valid/ready stream, sequences the core's request/acknowledge protocol, and returns results on a downstream valid/ready stream. It sits between the system bus adapter and the SIMON_4872 instance, replacing hand-driven bench stimulus in the integrated design.

---
 rtl/simon_host_pkg.sv | 30 +++
 rtl/simon_host_timer.sv | 31 +++
 rtl/simon_host_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_simon_host_ctrl.sv | 365 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/simon_host_pkg.sv
// Shared types, default widths and SIMON 48/72 reference constants for the
// SIMON host controller.
package simon_host_pkg;

    localparam int N_DEF = 24;
    localparam int M_DEF = 3;
    localparam int BLK_W = 2 * N_DEF;
    localparam int KEY_W = M_DEF * N_DEF;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        KEY_REQ   = 3'd1,
        KEY_WAIT  = 3'd2,
        READY     = 3'd3,
        DATA_REQ  = 3'd4,
        DATA_WAIT = 3'd5,
        READ_ACK  = 3'd6
    } state_t;

    // Published SIMON 48/72 test vector
    localparam logic [KEY_W-1:0] TV_KEY    = 72'h121110_0A0908_020100;
    localparam logic [BLK_W-1:0] TV_PLAIN  = 48'h6120676E696C;
    localparam logic [BLK_W-1:0] TV_CIPHER = 48'hDAE5AC292CAC;

    // States in which a core transaction is outstanding
    function automatic logic is_busy(input state_t s);
        return (s != IDLE) && (s != READY);
    endfunction

endpackage

// File: rtl/simon_host_timer.sv
// Clearable, saturating response timer. clr marks the first cycle of a new
// state: the visible count reads zero in that cycle regardless of history.
module simon_host_timer #(
    parameter int TERM = 1023,
    parameter int W    = $clog2(TERM + 1)
) (
    input  logic clk,
    input  logic R,
    input  logic clr,
    input  logic en,
    output logic term
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_eff;

    assign cnt_eff = clr ? '0 : cnt_q;
    assign term    = (cnt_eff == W'(TERM));

    // Advance the count while enabled, restarting on clr and holding at TERM
    always_ff @(posedge clk) begin
        if (R) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= en ? W'(1) : '0;
        end else if (en && (cnt_q != W'(TERM))) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/simon_host_ctrl.sv
// Stream-to-core initiator for the SIMON 48/72 key/data handshakes.
module simon_host_ctrl
    import simon_host_pkg::*;
#(
    parameter int N       = N_DEF,
    parameter int M       = M_DEF,
    parameter int TIMEOUT = 1023,
    parameter int CW      = 16
) (
    input  logic           clk,
    input  logic           R,
    input  logic           key_valid,
    input  logic [M*N-1:0] key_in,
    output logic           key_ready,
    input  logic           in_valid,
    input  logic [2*N-1:0] in_data,
    input  logic           in_enc_dec,
    output logic           in_ready,
    output logic           out_valid,
    output logic [2*N-1:0] out_data,
    input  logic           out_ready,
    output logic           newKey,
    output logic           newData,
    output logic           readData,
    output logic           enc_dec,
    output logic [M*N-1:0] key,
    output logic [2*N-1:0] plain,
    input  logic           ldKey,
    input  logic           doneKey,
    input  logic           ldData,
    input  logic           doneData,
    input  logic [2*N-1:0] cipher,
    output logic           key_loaded,
    output logic           busy,
    output logic           err,
    output logic [CW-1:0]  blk_count
);

    state_t state;
    logic   ready_q;    // registered "in READY" flag behind in_ready
    logic   entered;    // first cycle of a newly entered state
    logic   room;       // output register free (or being drained) this cycle
    logic   tmo_en;
    logic   tmo_term;
    logic   tmo_hit;
    logic   key_take;
    logic   blk_take;

    // A pending key always beats a pending block
    assign in_ready = ready_q && !key_valid;
    assign room     = !out_valid || out_ready;
    assign key_take = key_valid && key_ready;
    assign blk_take = in_valid && in_ready;
    assign tmo_hit  = tmo_term && is_busy(state);

    // Timer runs only while waiting on the core, and not while output is stalled
    always_comb begin
        tmo_en = 1'b0;
        case (state)
            KEY_REQ, KEY_WAIT, DATA_REQ, READ_ACK: tmo_en = 1'b1;
            DATA_WAIT:                             tmo_en = room;
            default:                               tmo_en = 1'b0;
        endcase
    end

    simon_host_timer #(.TERM(TIMEOUT)) u_timer (
        .clk  (clk),
        .R    (R),
        .clr  (entered),
        .en   (tmo_en),
        .term (tmo_term)
    );

    // Handshake sequencer with all outputs registered
    always_ff @(posedge clk) begin
        if (R) begin
            state      <= IDLE;
            ready_q    <= 1'b0;
            entered    <= 1'b0;
            newKey     <= 1'b0;
            newData    <= 1'b0;
            readData   <= 1'b0;
            enc_dec    <= 1'b1;
            key        <= '0;
            plain      <= '0;
            key_ready  <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
            key_loaded <= 1'b0;
            busy       <= 1'b0;
            err        <= 1'b0;
            blk_count  <= '0;
        end else begin
            entered <= 1'b0;
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            if (tmo_hit) begin
                state      <= IDLE;
                entered    <= 1'b1;
                newKey     <= 1'b0;
                newData    <= 1'b0;
                readData   <= 1'b0;
                key_loaded <= 1'b0;
                err        <= 1'b1;
                key_ready  <= 1'b1;
                ready_q    <= 1'b0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE, READY: begin
                        key_ready <= 1'b1;
                        ready_q   <= (state == READY);
                        if (key_take) begin
                            key        <= key_in;
                            key_loaded <= 1'b0;
                            newKey     <= 1'b1;
                            state      <= KEY_REQ;
                            entered    <= 1'b1;
                            key_ready  <= 1'b0;
                            ready_q    <= 1'b0;
                            busy       <= 1'b1;
                        end else if (blk_take) begin
                            plain     <= in_data;
                            enc_dec   <= in_enc_dec;
                            newData   <= 1'b1;
                            state     <= DATA_REQ;
                            entered   <= 1'b1;
                            key_ready <= 1'b0;
                            ready_q   <= 1'b0;
                            busy      <= 1'b1;
                        end
                    end
                    KEY_REQ: begin
                        if (ldKey) begin
                            newKey  <= 1'b0;
                            state   <= KEY_WAIT;
                            entered <= 1'b1;
                        end
                    end
                    KEY_WAIT: begin
                        if (doneKey) begin
                            key_loaded <= 1'b1;
                            state      <= READY;
                            entered    <= 1'b1;
                            key_ready  <= 1'b1;
                            ready_q    <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                    DATA_REQ: begin
                        if (ldData) begin
                            newData <= 1'b0;
                            state   <= DATA_WAIT;
                            entered <= 1'b1;
                        end
                    end
                    DATA_WAIT: begin
                        if (doneData && room) begin
                            out_data  <= cipher;
                            out_valid <= 1'b1;
                            readData  <= 1'b1;
                            state     <= READ_ACK;
                            entered   <= 1'b1;
                        end
                    end
                    READ_ACK: begin
                        if (!doneData) begin
                            readData  <= 1'b0;
                            blk_count <= blk_count + CW'(1);
                            state     <= READY;
                            entered   <= 1'b1;
                            key_ready <= 1'b1;
                            ready_q   <= 1'b1;
                            busy      <= 1'b0;
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        entered <= 1'b1;
                        busy    <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_simon_host_ctrl.sv
// Self-checking bench for simon_host_ctrl with a behavioural SIMON 48/72 core.
module tb_simon_host_ctrl;
    import simon_host_pkg::*;

    localparam int TMO    = 1023;
    localparam int BUDGET = 200;

    logic        clk = 1'b0;
    logic        R;
    logic        key_valid;
    logic [71:0] key_in;
    logic        key_ready;
    logic        in_valid;
    logic [47:0] in_data;
    logic        in_enc_dec;
    logic        in_ready;
    logic        out_valid;
    logic [47:0] out_data;
    logic        out_ready;
    logic        newKey, newData, readData, enc_dec;
    logic [71:0] key;
    logic [47:0] plain;
    logic        ldKey = 1'b0, doneKey = 1'b0, ldData = 1'b0, doneData = 1'b0;
    logic [47:0] cipher = 48'h0;
    logic        key_loaded, busy, err;
    logic [15:0] blk_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    simon_host_ctrl #(.N(24), .M(3), .TIMEOUT(TMO), .CW(16)) dut (
        .clk(clk), .R(R),
        .key_valid(key_valid), .key_in(key_in), .key_ready(key_ready),
        .in_valid(in_valid), .in_data(in_data), .in_enc_dec(in_enc_dec), .in_ready(in_ready),
        .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
        .newKey(newKey), .newData(newData), .readData(readData), .enc_dec(enc_dec),
        .key(key), .plain(plain),
        .ldKey(ldKey), .doneKey(doneKey), .ldData(ldData), .doneData(doneData),
        .cipher(cipher),
        .key_loaded(key_loaded), .busy(busy), .err(err), .blk_count(blk_count)
    );

    // ---------------- SIMON 48/72 reference model ----------------
    function automatic logic [23:0] rol(input logic [23:0] x, input int s);
        return (x << s) | (x >> (24 - s));
    endfunction

    function automatic logic [23:0] ror(input logic [23:0] x, input int s);
        return (x >> s) | (x << (24 - s));
    endfunction

    function automatic logic [47:0] simon(input logic [71:0] k, input logic [47:0] b, input logic e);
        logic [23:0] rk [36];
        logic [30:0] u;
        logic [61:0] z;
        logic [23:0] x, y, t;
        u = 31'b1111101000100101011000011100110;
        z = {u, u};
        rk[0] = k[23:0];
        rk[1] = k[47:24];
        rk[2] = k[71:48];
        for (int i = 3; i < 36; i++) begin
            t = ror(rk[i-1], 3);
            t = t ^ ror(t, 1);
            rk[i] = ~rk[i-3] ^ t ^ {23'd0, z[61-(i-3)]} ^ 24'd3;
        end
        x = b[47:24];
        y = b[23:0];
        if (e) begin
            for (int i = 0; i < 36; i++) begin
                t = x;
                x = y ^ (rol(x, 1) & rol(x, 8)) ^ rol(x, 2) ^ rk[i];
                y = t;
            end
        end else begin
            for (int i = 35; i >= 0; i--) begin
                t = y;
                y = x ^ (rol(y, 1) & rol(y, 8)) ^ rol(y, 2) ^ rk[i];
                x = t;
            end
        end
        return {x, y};
    endfunction

    // ---------------- Behavioural core ----------------
    int          ks = 0, kc = 0, ds = 0, dc = 0;
    logic        tie_ld = 1'b0;
    logic [71:0] core_key = 72'h0;
    logic [47:0] core_blk = 48'h0;
    logic        core_enc = 1'b1;
    logic [47:0] core_res = 48'h0;

    // Core handshakes with fixed latencies; ldData can be suppressed via tie_ld
    always @(negedge clk) begin
        if (R) begin
            ks <= 0; kc <= 0; ds <= 0; dc <= 0;
            ldKey <= 1'b0; doneKey <= 1'b0; ldData <= 1'b0; doneData <= 1'b0;
            core_key <= 72'h0;
        end else begin
            case (ks)
                0: if (newKey) begin core_key <= key; kc <= 2; ks <= 1; end
                1: if (kc == 0) begin ldKey <= 1'b1; ks <= 2; end else kc <= kc - 1;
                2: if (!newKey) begin ldKey <= 1'b0; kc <= 3; ks <= 3; end
                3: if (kc == 0) begin doneKey <= 1'b1; ks <= 4; end else kc <= kc - 1;
                default: begin doneKey <= 1'b0; ks <= 0; end
            endcase
            case (ds)
                0: if (newData) begin core_blk <= plain; core_enc <= enc_dec; dc <= 1; ds <= 1; end
                1: if (dc == 0) begin
                       if (!tie_ld) begin ldData <= 1'b1; ds <= 2; end
                   end else dc <= dc - 1;
                2: if (!newData) begin
                       ldData <= 1'b0; core_res <= simon(core_key, core_blk, core_enc);
                       dc <= 4; ds <= 3;
                   end
                3: if (dc == 0) begin cipher <= core_res; doneData <= 1'b1; ds <= 4; end
                   else dc <= dc - 1;
                default: if (readData) begin doneData <= 1'b0; ds <= 0; end
            endcase
        end
    end

    // ---------------- Monitors ----------------
    logic [47:0] got_q [$];
    int key_hs = 0;
    int nd_rd  = 0;

    // Record delivered results and count key handshakes / request overlaps
    always @(posedge clk) begin
        if (!R && out_valid && out_ready) got_q.push_back(out_data);
        if (!R && newKey && ldKey) key_hs <= key_hs + 1;
        if (!R && newData && readData) nd_rd <= nd_rd + 1;
    end

    // ---------------- Helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic send_key(input logic [71:0] k);
        logic acc;
        acc = 1'b0;
        key_valid = 1'b1;
        key_in    = k;
        for (int c = 0; c < BUDGET && !acc; c++) begin
            acc = key_ready;
            step();
        end
        key_valid = 1'b0;
        chk("key_accept", acc, 1);
    endtask

    task automatic send_blk(input logic [47:0] d, input logic e);
        logic acc;
        acc = 1'b0;
        in_valid   = 1'b1;
        in_data    = d;
        in_enc_dec = e;
        #1;
        for (int c = 0; c < BUDGET && !acc; c++) begin
            acc = in_ready;
            step();
        end
        in_valid = 1'b0;
        chk("blk_accept", acc, 1);
    endtask

    task automatic get_result(output logic [47:0] d);
        for (int c = 0; c < BUDGET && !out_valid; c++) step();
        chk("result_valid", out_valid, 1);
        d = out_data;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic wait_ready();
        for (int c = 0; c < BUDGET && !(key_ready && !busy); c++) step();
        chk("reach_ready", key_ready && !busy, 1);
    endtask

    task automatic wait_loaded();
        for (int c = 0; c < BUDGET && !key_loaded; c++) step();
        chk("key_loaded", key_loaded, 1);
    endtask

    typedef struct {
        logic [71:0] key;
        logic [47:0] blk;
        logic        enc;
        logic [47:0] exp;
        logic [15:0] cnt;
    } vec_t;

    vec_t        vec [4];
    logic [47:0] b2b [5];
    logic [47:0] d;
    logic [71:0] k2, k3;
    logic [47:0] p2, pa, pb, p3;

    initial begin
        R = 1'b1; key_valid = 1'b0; key_in = 72'h0; in_valid = 1'b0;
        in_data = 48'h0; in_enc_dec = 1'b0; out_ready = 1'b0;
        k2 = 72'h0F0E0D_0C0B0A_090807;
        k3 = 72'hA5A5A5_5A5A5A_C3C3C3;
        p2 = 48'h0011_2233_4455;
        pa = 48'h0123_4567_89AB;
        pb = 48'hFEDC_BA98_7654;
        p3 = 48'h1357_9BDF_0246;

        vec[0] = '{TV_KEY, TV_PLAIN,  1'b1, TV_CIPHER, 16'd1};
        vec[1] = '{TV_KEY, TV_CIPHER, 1'b0, TV_PLAIN,  16'd2};
        vec[2] = '{k2, p2, 1'b1, simon(k2, p2, 1'b1), 16'd3};
        vec[3] = '{k2, simon(k2, p2, 1'b1), 1'b0, p2, 16'd4};
        b2b[0] = 48'h6120676E696C; b2b[1] = 48'hA8D5F7DE0123; b2b[2] = 48'h5BC92D014567;
        b2b[3] = 48'hF2B48D4589AB; b2b[4] = 48'h567F11DECDEF;

        // Reset state
        repeat (2) step();
        R = 1'b0;
        chk("rst_key_ready", key_ready, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_enc_dec", enc_dec, 1);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        chk("rst_blk_count", blk_count, 0);
        step();
        chk("idle_key_ready", key_ready, 1);
        chk("idle_in_ready", in_ready, 0);

        // Table-driven key/data transactions
        for (int i = 0; i < 4; i++) begin
            if (i == 0 || vec[i].key != vec[i-1].key) begin
                send_key(vec[i].key);
                chk("key_loaded_cleared", key_loaded, 0);
                wait_loaded();
                chk("core_key", key, vec[i].key);
            end
            if (i == 0) chk("one_key_handshake", key_hs, 1);
            send_blk(vec[i].blk, vec[i].enc);
            get_result(d);
            chk($sformatf("vec%0d_out", i), d, vec[i].exp);
            wait_ready();
            chk($sformatf("vec%0d_count", i), blk_count, vec[i].cnt);
        end

        // Five back-to-back blocks with out_ready held high
        R = 1'b1;
        step();
        R = 1'b0;
        chk("b2b_count_reset", blk_count, 0);
        send_key(TV_KEY);
        wait_loaded();
        got_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) send_blk(b2b[i], 1'b1);
        for (int c = 0; c < 5 * BUDGET && got_q.size() < 5; c++) step();
        chk("b2b_results", got_q.size(), 5);
        if (got_q.size() == 5) begin
            chk("b2b_first", got_q[0], TV_CIPHER);
            for (int i = 1; i < 5; i++) chk($sformatf("b2b_%0d", i), got_q[i], simon(TV_KEY, b2b[i], 1'b1));
        end
        wait_ready();
        chk("b2b_count", blk_count, 5);
        chk("no_newdata_in_read_ack", nd_rd, 0);
        out_ready = 1'b0;

        // Downstream backpressure on the second result
        send_blk(pa, 1'b1);
        for (int c = 0; c < BUDGET && !out_valid; c++) step();
        chk("bp_first_data", out_data, simon(TV_KEY, pa, 1'b1));
        wait_ready();
        send_blk(pb, 1'b1);
        for (int c = 0; c < BUDGET && !doneData; c++) step();
        chk("bp_done_seen", doneData, 1);
        repeat (4) step();
        chk("bp_readdata_low", readData, 0);
        chk("bp_no_overwrite", out_data, simon(TV_KEY, pa, 1'b1));
        chk("bp_busy", busy, 1);
        out_ready = 1'b1;
        step();
        chk("bp_swap_valid", out_valid, 1);
        chk("bp_second_data", out_data, simon(TV_KEY, pb, 1'b1));
        chk("bp_readdata_high", readData, 1);
        step();
        chk("bp_drained", out_valid, 0);
        out_ready = 1'b0;
        wait_ready();
        chk("bp_err", err, 0);

        // Key and block offered together: key wins, block then uses the new key
        key_valid = 1'b1; key_in = k3;
        in_valid = 1'b1; in_data = p3; in_enc_dec = 1'b1;
        #1;
        chk("prio_in_ready", in_ready, 0);
        chk("prio_key_ready", key_ready, 1);
        step();
        key_valid = 1'b0;
        chk("prio_key_taken", key_loaded, 0);
        chk("prio_key_latched", key, k3);
        send_blk(p3, 1'b1);
        get_result(d);
        chk("prio_new_key_result", d, simon(k3, p3, 1'b1));
        wait_ready();

        // Core never acknowledges data: timeout
        tie_ld = 1'b1;
        send_blk(p3, 1'b1);
        chk("tmo_request", newData, 1);
        repeat (TMO) step();
        chk("tmo_not_yet", err, 0);
        step();
        chk("tmo_err", err, 1);
        chk("tmo_key_loaded", key_loaded, 0);
        chk("tmo_newdata", newData, 0);
        chk("tmo_busy", busy, 0);
        repeat (3) step();
        chk("tmo_sticky", err, 1);
        chk("tmo_idle_in_ready", in_ready, 0);

        // Reset clears err; reset in DATA_WAIT abandons the transaction
        R = 1'b1;
        tie_ld = 1'b0;
        step();
        R = 1'b0;
        chk("rst_clears_err", err, 0);
        step();
        send_key(TV_KEY);
        wait_loaded();
        send_blk(TV_CIPHER, 1'b0);
        for (int c = 0; c < BUDGET && ds != 3; c++) step();
        chk("reach_data_wait", ds, 3);
        R = 1'b1;
        step();
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_plain", plain, 0);
        chk("mid_rst_key", key, 0);
        chk("mid_rst_enc_dec", enc_dec, 1);
        chk("mid_rst_key_loaded", key_loaded, 0);
        chk("mid_rst_key_ready", key_ready, 0);
        chk("mid_rst_requests", {newKey, newData, readData}, 0);
        chk("mid_rst_out", {out_valid, out_data}, 0);
        chk("mid_rst_count", blk_count, 0);
        R = 1'b0;
        step();
        chk("post_rst_key_ready", key_ready, 1);
        chk("post_rst_in_ready", in_ready, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
